// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers used by the bus-mux slice.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Bit positions of each downstream target in the one-hot select.
    localparam int SLV0 = 0;
    localparam int SLV1 = 1;
    localparam int BRGA = 2;
    localparam int BRGB = 3;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // True when exactly one bit of a 4-bit select is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped transfers with the two-cycle ERROR response.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hresetn,
    input  logic unmapped,
    input  logic hready_in,
    output logic ds_active,
    output logic ds_hready,
    output logic ds_hresp
);

    ds_state_t state;

    // State and registered outputs advance together so the response is glitch-free.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= DS_IDLE;
            ds_active <= 1'b0;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (unmapped && hready_in) begin
                        state     <= DS_ERR1;
                        ds_active <= 1'b1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    ds_active <= 1'b1;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // hready is high here, so a new unmapped address is being accepted.
                    if (unmapped && hready_in) begin
                        state     <= DS_ERR1;
                        ds_active <= 1'b1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        ds_active <= 1'b0;
                        ds_hready <= 1'b1;
                        ds_hresp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state     <= DS_IDLE;
                    ds_active <= 1'b0;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_bus_mux.sv
// Shared-bus routing stage behind the 3-master arbiter.
// Handshake: a transfer's address phase is accepted on a rising hclk edge
// where hready=1; its data phase then runs until the next hready=1 edge.
module ahb_bus_mux
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hgrant_1,
    input  logic              hgrant_2,
    input  logic              hgrant_3,
    input  logic [3:0]        sel,
    input  logic [ADDR_W-1:0] haddr_m1,
    input  logic [ADDR_W-1:0] haddr_m2,
    input  logic [ADDR_W-1:0] haddr_m3,
    input  logic [1:0]        htrans_m1,
    input  logic [1:0]        htrans_m2,
    input  logic [1:0]        htrans_m3,
    input  logic              hwrite_m1,
    input  logic              hwrite_m2,
    input  logic              hwrite_m3,
    input  logic [2:0]        hsize_m1,
    input  logic [2:0]        hsize_m2,
    input  logic [2:0]        hsize_m3,
    input  logic [DATA_W-1:0] hwdata_m1,
    input  logic [DATA_W-1:0] hwdata_m2,
    input  logic [DATA_W-1:0] hwdata_m3,
    input  logic [DATA_W-1:0] hrdata_s0,
    input  logic [DATA_W-1:0] hrdata_s1,
    input  logic [DATA_W-1:0] hrdata_s2,
    input  logic [DATA_W-1:0] hrdata_s3,
    input  logic              hreadyout_s0,
    input  logic              hreadyout_s1,
    input  logic              hreadyout_s2,
    input  logic              hreadyout_s3,
    input  logic              hresp_s0,
    input  logic              hresp_s1,
    input  logic              hresp_s2,
    input  logic              hresp_s3,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    output logic [3:0]        hsel,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    output logic              hresp,
    output logic              grant_err
);

    logic [2:0] gnt_oh;
    logic       active;
    logic       unmapped;
    logic [1:0] gnt_cnt;

    logic [2:0] dmaster;
    logic [3:0] dsel;
    logic       dvalid;
    logic       dunmapped;

    logic ds_active;
    logic ds_hready;
    logic ds_hresp;

    // Address-phase master mux, priority 1 > 2 > 3; IDLE when nobody is granted.
    always_comb begin
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = 3'b000;
        gnt_oh = 3'b000;
        if (hgrant_1) begin
            haddr  = haddr_m1;
            htrans = htrans_m1;
            hwrite = hwrite_m1;
            hsize  = hsize_m1;
            gnt_oh = 3'b001;
        end else if (hgrant_2) begin
            haddr  = haddr_m2;
            htrans = htrans_m2;
            hwrite = hwrite_m2;
            hsize  = hsize_m2;
            gnt_oh = 3'b010;
        end else if (hgrant_3) begin
            haddr  = haddr_m3;
            htrans = htrans_m3;
            hwrite = hwrite_m3;
            hsize  = hsize_m3;
            gnt_oh = 3'b100;
        end
    end

    assign active   = htrans[1];
    assign hsel     = (active && is_onehot4(sel)) ? sel : 4'b0000;
    assign unmapped = active && !is_onehot4(sel);
    assign gnt_cnt  = {1'b0, hgrant_1} + {1'b0, hgrant_2} + {1'b0, hgrant_3};

    // Data-phase selects advance only when the bus accepts the address phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dmaster   <= 3'b000;
            dsel      <= 4'b0000;
            dvalid    <= 1'b0;
            dunmapped <= 1'b0;
        end else if (hready) begin
            dmaster   <= gnt_oh;
            dsel      <= hsel;
            dvalid    <= active;
            dunmapped <= unmapped;
        end
    end

    // Flag a cycle in which the arbiter raised more than one grant.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            grant_err <= 1'b0;
        end else begin
            grant_err <= (gnt_cnt > 2'd1);
        end
    end

    // Write data follows the master that owned the previous accepted address.
    always_comb begin
        hwdata = '0;
        if (dmaster[0]) begin
            hwdata = hwdata_m1;
        end else if (dmaster[1]) begin
            hwdata = hwdata_m2;
        end else if (dmaster[2]) begin
            hwdata = hwdata_m3;
        end
    end

    // Response mux; the default slave owns the bus while it is signalling ERROR.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        if (ds_active) begin
            hready = ds_hready;
            hresp  = ds_hresp;
        end else if (dvalid && !dunmapped) begin
            if (dsel[SLV0]) begin
                hrdata = hrdata_s0;
                hready = hreadyout_s0;
                hresp  = hresp_s0;
            end else if (dsel[SLV1]) begin
                hrdata = hrdata_s1;
                hready = hreadyout_s1;
                hresp  = hresp_s1;
            end else if (dsel[BRGA]) begin
                hrdata = hrdata_s2;
                hready = hreadyout_s2;
                hresp  = hresp_s2;
            end else if (dsel[BRGB]) begin
                hrdata = hrdata_s3;
                hready = hreadyout_s3;
                hresp  = hresp_s3;
            end
        end
    end

    ahb_default_slave u_ds (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .unmapped  (unmapped),
        .hready_in (hready),
        .ds_active (ds_active),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp)
    );

endmodule

// File: tb/tb_ahb_bus_mux.sv
// Self-checking bench for ahb_bus_mux: directed scenarios then random traffic,
// every cycle compared against a transfer-level model of the bus.
module tb_ahb_bus_mux;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic hclk = 1'b0;
    logic hresetn;
    always #5 hclk = ~hclk;

    // ---------------- stimulus storage (index 0 = "nobody", tied to zero) -----
    logic          g1, g2, g3;
    logic [3:0]    sel;
    logic [AW-1:0] m_addr  [0:3];
    logic [1:0]    m_trans [0:3];
    logic          m_write [0:3];
    logic [2:0]    m_size  [0:3];
    logic [DW-1:0] m_wdata [0:3];
    logic [DW-1:0] s_rdata [0:3];
    logic          s_ready [0:3];
    logic          s_resp  [0:3];

    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [DW-1:0] hwdata;
    logic [3:0]    hsel;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;
    logic          grant_err;

    int checks = 0;
    int errors = 0;

    ahb_bus_mux #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .hgrant_1(g1), .hgrant_2(g2), .hgrant_3(g3), .sel(sel),
        .haddr_m1(m_addr[1]), .haddr_m2(m_addr[2]), .haddr_m3(m_addr[3]),
        .htrans_m1(m_trans[1]), .htrans_m2(m_trans[2]), .htrans_m3(m_trans[3]),
        .hwrite_m1(m_write[1]), .hwrite_m2(m_write[2]), .hwrite_m3(m_write[3]),
        .hsize_m1(m_size[1]), .hsize_m2(m_size[2]), .hsize_m3(m_size[3]),
        .hwdata_m1(m_wdata[1]), .hwdata_m2(m_wdata[2]), .hwdata_m3(m_wdata[3]),
        .hrdata_s0(s_rdata[0]), .hrdata_s1(s_rdata[1]),
        .hrdata_s2(s_rdata[2]), .hrdata_s3(s_rdata[3]),
        .hreadyout_s0(s_ready[0]), .hreadyout_s1(s_ready[1]),
        .hreadyout_s2(s_ready[2]), .hreadyout_s3(s_ready[3]),
        .hresp_s0(s_resp[0]), .hresp_s1(s_resp[1]),
        .hresp_s2(s_resp[2]), .hresp_s3(s_resp[3]),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hsel(hsel), .hrdata(hrdata), .hready(hready),
        .hresp(hresp), .grant_err(grant_err)
    );

    // ---------------- reference model ----------------
    // Pending data phase: which slave (-1 none), which master (0 none),
    // and where in the two-cycle error response we are (0 none, 1 first, 2 second).
    int  p_slave;
    int  p_master;
    int  err_ph;
    bit  exp_gerr;

    // Values the model derived for the current cycle, reused at the clock edge.
    int            e_g;
    int            e_slave_next;
    bit            e_unm;
    bit            e_hready;

    task automatic model_reset();
        p_slave  = -1;
        p_master = 0;
        err_ph   = 0;
        exp_gerr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the model says this cycle.
    task automatic check_all();
        int  cnt;
        bit  act;
        bit  oh;
        logic [3:0] e_hsel;
        bit  e_hresp;
        logic [DW-1:0] e_hrdata;
        e_g = g1 ? 1 : (g2 ? 2 : (g3 ? 3 : 0));
        act = m_trans[e_g][1];
        cnt = 0;
        e_slave_next = -1;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                cnt++;
                e_slave_next = i;
            end
        end
        oh = (cnt == 1);
        if (!(act && oh)) e_slave_next = -1;
        e_unm  = act && !oh;
        e_hsel = (act && oh) ? sel : 4'b0000;

        if (err_ph == 1) begin
            e_hready = 1'b0; e_hresp = 1'b1; e_hrdata = '0;
        end else if (err_ph == 2) begin
            e_hready = 1'b1; e_hresp = 1'b1; e_hrdata = '0;
        end else if (p_slave >= 0) begin
            e_hready = s_ready[p_slave]; e_hresp = s_resp[p_slave]; e_hrdata = s_rdata[p_slave];
        end else begin
            e_hready = 1'b1; e_hresp = 1'b0; e_hrdata = '0;
        end
        if (!hresetn) begin
            e_hready = 1'b1; e_hresp = 1'b0; e_hrdata = '0;
        end

        chk("haddr", haddr, m_addr[e_g]);
        chk("htrans", htrans, m_trans[e_g]);
        chk("hwrite", hwrite, m_write[e_g]);
        chk("hsize", hsize, m_size[e_g]);
        chk("hsel", hsel, e_hsel);
        chk("hwdata", hwdata, m_wdata[p_master]);
        chk("hrdata", hrdata, e_hrdata);
        chk("hready", hready, e_hready);
        chk("hresp", hresp, e_hresp);
        chk("grant_err", grant_err, exp_gerr);
    endtask

    // Advance the model across a rising edge using this cycle's derived values.
    task automatic model_step();
        if (!hresetn) begin
            model_reset();
        end else begin
            if (err_ph == 1)                 err_ph = 2;
            else if (e_hready && e_unm)      err_ph = 1;
            else if (err_ph == 2)            err_ph = 0;
            if (e_hready) begin
                p_master = e_g;
                p_slave  = e_slave_next;
            end
            exp_gerr = (int'(g1) + int'(g2) + int'(g3)) > 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic mid();
        #4;
        check_all();
    endtask

    task automatic edge_step();
        @(posedge hclk);
        model_step();
        #1;
    endtask

    task automatic tick();
        mid();
        edge_step();
    endtask

    task automatic drive_idle();
        g1 = 0; g2 = 0; g3 = 0; sel = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = '0; m_trans[i] = HTRANS_IDLE; m_write[i] = 0;
            m_size[i] = 3'b000; m_wdata[i] = '0;
            s_rdata[i] = '0; s_ready[i] = 1; s_resp[i] = 0;
        end
    endtask

    task automatic set_m(input int m, input logic [AW-1:0] a, input logic [1:0] t,
                         input logic w, input logic [DW-1:0] d);
        m_addr[m] = a; m_trans[m] = t; m_write[m] = w; m_size[m] = 3'b010; m_wdata[m] = d;
    endtask

    // ---------------- directed steps, then random traffic ----------------
    initial begin
        drive_idle();
        model_reset();
        hresetn = 0;
        #2;
        mid();
        chk("reset_ds_state", dut.u_ds.state, DS_IDLE);
        edge_step();
        hresetn = 1;
        tick();

        // 1: M1 NONSEQ write to slave0
        g1 = 1; sel = 4'b0001;
        set_m(1, 32'h10, HTRANS_NONSEQ, 1, 32'hDEADBEEF);
        mid();
        chk("t1_hsel", hsel, 4'b0001);
        chk("t1_haddr", haddr, 32'h10);
        edge_step();
        m_trans[1] = HTRANS_IDLE;
        mid();
        chk("t1_hwdata", hwdata, 32'hDEADBEEF);
        chk("t1_hready", hready, 1'b1);
        chk("t1_hresp", hresp, 1'b0);
        edge_step();

        // 2: M2 reads slave1 with two wait states
        g1 = 0; g2 = 1; sel = 4'b0010;
        set_m(2, 32'h20, HTRANS_NONSEQ, 0, 32'h0);
        s_rdata[1] = 32'h12345678; s_ready[1] = 0;
        tick();
        m_trans[2] = HTRANS_IDLE;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("t2_wait_hready", hready, 1'b0);
            chk("t2_dsel_held", dut.dsel, 4'b0010);
            edge_step();
        end
        s_ready[1] = 1;
        mid();
        chk("t2_hready", hready, 1'b1);
        chk("t2_hrdata", hrdata, 32'h12345678);
        edge_step();

        // 3: M3 to an unmapped select -> two-cycle ERROR from the default slave
        g2 = 0; g3 = 1; sel = 4'b0000;
        set_m(3, 32'h30, HTRANS_NONSEQ, 0, 32'h0);
        mid();
        chk("t3_hsel", hsel, 4'b0000);
        edge_step();
        m_trans[3] = HTRANS_IDLE;
        mid();
        chk("t3_err1_hready", hready, 1'b0);
        chk("t3_err1_hresp", hresp, 1'b1);
        edge_step();
        mid();
        chk("t3_err2_hready", hready, 1'b1);
        chk("t3_err2_hresp", hresp, 1'b1);
        edge_step();
        mid();
        chk("t3_done_hready", hready, 1'b1);
        chk("t3_done_hresp", hresp, 1'b0);
        edge_step();

        // 4: back-to-back writes from M2 then M3
        g3 = 0; g2 = 1; sel = 4'b0001;
        set_m(2, 32'h40, HTRANS_NONSEQ, 1, 32'hAAAA0000);
        mid();
        chk("t4_hsel0", hsel, 4'b0001);
        edge_step();
        g2 = 0; g3 = 1; sel = 4'b0100; m_trans[2] = HTRANS_IDLE;
        set_m(3, 32'h50, HTRANS_NONSEQ, 1, 32'h5555FFFF);
        mid();
        chk("t4_hsel1", hsel, 4'b0100);
        chk("t4_hwdata0", hwdata, 32'hAAAA0000);
        edge_step();
        m_trans[3] = HTRANS_IDLE;
        mid();
        chk("t4_hwdata1", hwdata, 32'h5555FFFF);
        edge_step();

        // 5: two grants at once -> M1 wins, grant_err pulses one cycle later
        g1 = 1; g3 = 1; sel = 4'b0010;
        set_m(1, 32'h100, HTRANS_NONSEQ, 0, 32'h0);
        set_m(3, 32'h300, HTRANS_NONSEQ, 1, 32'h0);
        mid();
        chk("t5_haddr", haddr, 32'h100);
        chk("t5_hsel", hsel, 4'b0010);
        chk("t5_gerr_pre", grant_err, 1'b0);
        edge_step();
        g3 = 0; m_trans[1] = HTRANS_IDLE; m_trans[3] = HTRANS_IDLE;
        mid();
        chk("t5_gerr", grant_err, 1'b1);
        edge_step();
        mid();
        chk("t5_gerr_post", grant_err, 1'b0);
        edge_step();

        // 6: reset asserted during a slave wait state
        g1 = 0; g2 = 1; sel = 4'b0010;
        set_m(2, 32'h24, HTRANS_NONSEQ, 0, 32'h0);
        s_ready[1] = 0;
        tick();
        m_trans[2] = HTRANS_IDLE;
        mid();
        chk("t6_wait", hready, 1'b0);
        hresetn = 0;
        #1;
        model_reset();
        chk("t6_hready", hready, 1'b1);
        chk("t6_hresp", hresp, 1'b0);
        chk("t6_dsel", dut.dsel, 4'b0000);
        chk("t6_ds_state", dut.u_ds.state, DS_IDLE);
        edge_step();
        drive_idle();
        hresetn = 1;
        tick();
        chk("t6_after_htrans", htrans, HTRANS_IDLE);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            g1 = 0; g2 = 0; g3 = 0;
            if (r == 1) begin
                g1 = 1'($urandom_range(0, 1));
                g2 = 1'($urandom_range(0, 1));
                g3 = 1'($urandom_range(0, 1));
            end else if (r >= 2) begin
                case ($urandom_range(1, 3))
                    1:       g1 = 1;
                    2:       g2 = 1;
                    default: g3 = 1;
                endcase
            end
            if ($urandom_range(0, 5) != 0) sel = 4'b0001 << $urandom_range(0, 3);
            else                           sel = 4'($urandom_range(0, 15));
            for (int m = 1; m <= 3; m++) begin
                m_addr[m]  = $urandom;
                m_trans[m] = 2'($urandom_range(0, 3));
                m_write[m] = 1'($urandom_range(0, 1));
                m_size[m]  = 3'($urandom_range(0, 7));
                m_wdata[m] = $urandom;
            end
            for (int s = 0; s < 4; s++) begin
                s_rdata[s] = $urandom;
                s_ready[s] = ($urandom_range(0, 3) != 0);
                s_resp[s]  = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_bus_mux.md
Name: ahb_bus_mux

Overview:
- Shared-bus routing stage directly downstream of the 3-master arbiter. Consumes `hgrant_1..3` and the 4-bit one-hot `sel`.
- Muxes the granted master's address/control onto the shared bus and drives per-slave `hsel`.
- Pipelines the data-phase selects, so write data and slave responses are routed one transfer later than the address phase, per AHB.
- Contains a default slave that gives the two-cycle ERROR response for unmapped selects. Its `hready`/`hresp` outputs feed the arbiter's `hready_out`/`hresp` inputs.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read/write data width

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  asynchronous, active-low reset
- hgrant_1, hgrant_2, hgrant_3  in  1 each  grants from arbiter
- sel  in  4  one-hot slave select from arbiter: [0] slave0, [1] slave1, [2] bridge A, [3] bridge B
- haddr_m1, haddr_m2, haddr_m3  in  ADDR_W each  master addresses
- htrans_m1, htrans_m2, htrans_m3  in  2 each  master transfer type
- hwrite_m1, hwrite_m2, hwrite_m3  in  1 each  master write strobe
- hsize_m1, hsize_m2, hsize_m3  in  3 each  master transfer size
- hwdata_m1, hwdata_m2, hwdata_m3  in  DATA_W each  master write data
- hrdata_s0..hrdata_s3  in  DATA_W each  slave read data
- hreadyout_s0..hreadyout_s3  in  1 each  slave ready
- hresp_s0..hresp_s3  in  1 each  slave response (1 = ERROR)
- haddr  out  ADDR_W  shared address
- htrans  out  2  shared transfer type
- hwrite  out  1  shared write strobe
- hsize  out  3  shared transfer size
- hwdata  out  DATA_W  shared write data
- hsel  out  4  per-slave select
- hrdata  out  DATA_W  read data to masters
- hready  out  1  bus ready, to masters and arbiter
- hresp  out  1  bus response, to masters and arbiter
- grant_err  out  1  registered pulse: more than one grant high in a cycle

Behaviour:

Address phase (combinational):
- Master mux keyed on grants, priority 1 > 2 > 3.
- No grant: htrans=IDLE(00), haddr=0, hwrite=0, hsize=0.
- active = htrans[1] (NONSEQ or SEQ).
- hsel = sel when active and sel is one-hot; otherwise 0.
- unmapped = active && sel not one-hot (this includes 0000).

Data-phase registers (capture on hclk only when hready=1; hold otherwise):
- dmaster[2:0], one-hot granted master; reset 0.
- dsel[3:0] = hsel; reset 0.
- dvalid = active; reset 0.
- dunmapped; reset 0.

Data-phase routing:
- hwdata is muxed by dmaster; 0 when dmaster=0.
- hrdata, hready and hresp are muxed by dsel.
- dsel=0 and default slave idle: hready=1, hresp=0, hrdata=0.

Default slave (FSM DS_IDLE, DS_ERR1, DS_ERR2):
- DS_IDLE -> DS_ERR1 when unmapped && hready are sampled.
- In DS_ERR1: hready=0, hresp=1. Next state DS_ERR2, unconditionally.
- In DS_ERR2: hready=1, hresp=1. Next state is DS_ERR1 if a new unmapped transfer is sampled this cycle, else DS_IDLE.
- While not in DS_IDLE, the default slave overrides the dsel mux outputs.

Wait states:
- hreadyout_sN=0 on the selected slave gives hready=0.
- Address outputs still follow the live grant; the arbiter holds the grant until tr_done.
- Data-phase registers are frozen for the duration.

Error case:
- A slave ERROR with hreadyout=1 passes through unchanged (slave-driven two-cycle response).

grant_err:
- Registered and asserted one cycle after a multi-grant cycle.
- Routing still uses priority during that cycle.

Reset:
- Asynchronous.
- Reset mid-operation abandons any pending data phase and returns the FSM to DS_IDLE.
- In reset: dsel/dmaster/dvalid/dunmapped=0, grant_err=0, hready=1, hresp=0, hrdata=0, hwdata=0.
- Address outputs follow the inputs (IDLE while no grant).

Latency:
- Address phase: 0 cycles.
- Data/response: 1 cycle after the address is accepted, plus slave wait states.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - slave index constants SLV0, SLV1, BRGA, BRGB
  - a one-hot check function.
- One sub-module: ahb_default_slave, containing the 3-state FSM with inputs hclk, hresetn, unmapped, hready_in and outputs ds_active, ds_hready, ds_hresp.

Test Plan:
1. M1 granted, sel=0001, NONSEQ write to haddr 0x10, hwdata_m1=0xDEADBEEF -> cycle 0: hsel=0001, haddr=0x10. Cycle 1: hwdata=0xDEADBEEF, hready=1, hresp=0.
2. M2 reads slave1, hreadyout_s1 low for 2 cycles, hrdata_s1=0x12345678 -> hready=0 for 2 cycles with dsel held at 0010. Then hready=1 and hrdata=0x12345678.
3. M3 NONSEQ with sel=0000 -> hsel=0000. Next cycle hready=0, hresp=1. Following cycle hready=1, hresp=1. Then hready=1, hresp=0.
4. Back-to-back: M2 writes slave0 (0xAAAA0000), then M3 writes bridge A (0x5555FFFF) on consecutive cycles -> hwdata is 0xAAAA0000 then 0x5555FFFF. hsel is 0001 then 0100, one cycle ahead of the data.
5. hgrant_1=hgrant_3=1 with sel=0010 -> M1 address routed, hsel=0010, grant_err=1 on the next cycle only.
6. hresetn pulsed low during scenario 2's wait state -> immediately hready=1, hresp=0, dsel=0, and the FSM is in DS_IDLE. The bus is idle after release.
